// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the pipeline hazard scheduler: FSM state encoding,
// forwarding-select codes and the architectural PC register number.
package hazard_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Operand source codes driven on fwd_a/fwd_b/fwd_c
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   // R15 is the PC: never a hazard source, never forwarded
   localparam int unsigned PC_REG = 15;

endpackage

// File: rtl/hazard_scheduler_fwd_select.sv
// Single-operand forwarding priority encoder. The youngest matching in-flight
// write wins; a load still in EX cannot supply data, so it is skipped.
module fwd_select
   import hazard_scheduler_pkg::*;
#(
   parameter int NREG_W = 4
) (
   input  logic [NREG_W-1:0] src_i,
   input  logic              ex_valid_i,
   input  logic [NREG_W-1:0] ex_rd_i,
   input  logic              ex_load_i,
   input  logic              mem_valid_i,
   input  logic [NREG_W-1:0] mem_rd_i,
   input  logic              wb_valid_i,
   input  logic [NREG_W-1:0] wb_rd_i,
   output logic [1:0]        sel_o
);

   localparam logic [NREG_W-1:0] PcReg = NREG_W'(PC_REG);

   // Pick the youngest valid producer of src_i, register file otherwise
   always_comb begin
      // NOTE: default assignment first so every path drives sel_o (no latch).
      sel_o = FWD_RF;
      if (src_i != PcReg) begin
         if (ex_valid_i && !ex_load_i && (ex_rd_i == src_i)) begin
            sel_o = FWD_EX;
         end else if (mem_valid_i && (mem_rd_i == src_i)) begin
            sel_o = FWD_MEM;
         end else if (wb_valid_i && (wb_rd_i == src_i)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_scheduler.sv
// Pipeline hazard controller for the 5-stage core: tracks in-flight register
// writes (EX/MEM/WB), inserts load-use bubbles, flushes after taken branches
// and selects operand forwarding sources.
module hazard_scheduler
   import hazard_scheduler_pkg::*;
#(
   parameter int LOAD_STALL = 1,
   parameter int NREG_W     = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREG_W-1:0] id_rn,
   input  logic [NREG_W-1:0] id_rm,
   input  logic [NREG_W-1:0] id_rd,
   input  logic              id_use_rn,
   input  logic              id_use_rm,
   input  logic              id_use_rd,
   input  logic              id_rf_e,
   input  logic [NREG_W-1:0] id_wr_reg,
   input  logic              id_load,
   input  logic              br_taken,
   output logic              cu_nop_s,
   output logic              pc_le,
   output logic              ifid_le,
   output logic              ifid_clr,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [1:0]        fwd_c,
   output logic [15:0]       stall_cnt
);

   localparam logic [NREG_W-1:0] PcReg = NREG_W'(PC_REG);

   // Scoreboard. Only the EX slot needs the load flag: once a load reaches
   // MEM its data is available for forwarding like any other result.
   logic              ex_valid_q, mem_valid_q, wb_valid_q;
   logic [NREG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
   logic              ex_load_q;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [15:0]       stall_cnt_q;

   logic              hit_rn, hit_rm, hit_rd;
   logic              hazard;
   logic              stall_evt;

   // Load-use detection against the load currently in EX
   assign hit_rn = id_use_rn && (id_rn == ex_rd_q) && (id_rn != PcReg);
   assign hit_rm = id_use_rm && (id_rm == ex_rd_q) && (id_rm != PcReg);
   assign hit_rd = id_use_rd && (id_rd == ex_rd_q) && (id_rd != PcReg);
   assign hazard = ex_valid_q && ex_load_q && (hit_rn || hit_rm || hit_rd);

   // State register and stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= 3'd0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; hazard beats branch, FLUSH evaluates neither
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_RUN: begin
            if (hazard) begin
               cnt_d   = 3'(LOAD_STALL - 1);
               state_d = (LOAD_STALL == 1) ? ST_RUN : ST_STALL;
            end else if (br_taken) begin
               state_d = ST_FLUSH;
            end
         end
         ST_STALL: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_d == 3'd0) begin
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // Control outputs; held at their idle values while reset is asserted
   always_comb begin
      cu_nop_s  = 1'b0;
      pc_le     = 1'b1;
      ifid_le   = 1'b1;
      ifid_clr  = 1'b0;
      stall_evt = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            ST_RUN: begin
               if (hazard) begin
                  cu_nop_s  = 1'b1;
                  pc_le     = 1'b0;
                  ifid_le   = 1'b0;
                  stall_evt = 1'b1;
               end else if (br_taken) begin
                  ifid_clr = 1'b1;
               end
            end
            ST_STALL: begin
               cu_nop_s  = 1'b1;
               pc_le     = 1'b0;
               ifid_le   = 1'b0;
               stall_evt = 1'b1;
            end
            ST_FLUSH: begin
               // Killed fetch sits in ID; null it but keep fetching
               cu_nop_s = 1'b1;
            end
            default: begin
               cu_nop_s = 1'b0;
            end
         endcase
      end
   end

   // Scoreboard shift; a nulled ID instruction enters EX as an empty slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         ex_rd_q     <= '0;
         ex_load_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_rd_q    <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
      end else begin
         ex_valid_q  <= id_rf_e && !cu_nop_s;
         ex_rd_q     <= id_wr_reg;
         ex_load_q   <= id_load;
         mem_valid_q <= ex_valid_q;
         mem_rd_q    <= ex_rd_q;
         wb_valid_q  <= mem_valid_q;
         wb_rd_q     <= mem_rd_q;
      end
   end

   // Saturating count of load-use bubble cycles (flush bubbles excluded)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= 16'd0;
      end else if (stall_evt && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;

   fwd_select #(.NREG_W(NREG_W)) u_fwd_a (
      .src_i       (id_rn),
      .ex_valid_i  (ex_valid_q),
      .ex_rd_i     (ex_rd_q),
      .ex_load_i   (ex_load_q),
      .mem_valid_i (mem_valid_q),
      .mem_rd_i    (mem_rd_q),
      .wb_valid_i  (wb_valid_q),
      .wb_rd_i     (wb_rd_q),
      .sel_o       (fwd_a)
   );

   fwd_select #(.NREG_W(NREG_W)) u_fwd_b (
      .src_i       (id_rm),
      .ex_valid_i  (ex_valid_q),
      .ex_rd_i     (ex_rd_q),
      .ex_load_i   (ex_load_q),
      .mem_valid_i (mem_valid_q),
      .mem_rd_i    (mem_rd_q),
      .wb_valid_i  (wb_valid_q),
      .wb_rd_i     (wb_rd_q),
      .sel_o       (fwd_b)
   );

   fwd_select #(.NREG_W(NREG_W)) u_fwd_c (
      .src_i       (id_rd),
      .ex_valid_i  (ex_valid_q),
      .ex_rd_i     (ex_rd_q),
      .ex_load_i   (ex_load_q),
      .mem_valid_i (mem_valid_q),
      .mem_rd_i    (mem_rd_q),
      .wb_valid_i  (wb_valid_q),
      .wb_rd_i     (wb_rd_q),
      .sel_o       (fwd_c)
   );

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: two instances (LOAD_STALL=1 and 3)
// share the same ID-stage stimulus; expected values are hand-derived.
module tb_hazard_scheduler;

   logic       clk;
   logic       rst_n;
   logic [3:0] id_rn, id_rm, id_rd, id_wr_reg;
   logic       id_use_rn, id_use_rm, id_use_rd;
   logic       id_rf_e, id_load, br_taken;

   logic        u1_nop, u1_pc_le, u1_ifid_le, u1_clr;
   logic [1:0]  u1_fwd_a, u1_fwd_b, u1_fwd_c;
   logic [15:0] u1_scnt;
   logic        u3_nop, u3_pc_le, u3_ifid_le, u3_clr;
   logic [1:0]  u3_fwd_a, u3_fwd_b, u3_fwd_c;
   logic [15:0] u3_scnt;

   int n_assert = 0;
   int n_fail   = 0;

   hazard_scheduler #(.LOAD_STALL(1), .NREG_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
      .id_rf_e(id_rf_e), .id_wr_reg(id_wr_reg), .id_load(id_load),
      .br_taken(br_taken),
      .cu_nop_s(u1_nop), .pc_le(u1_pc_le), .ifid_le(u1_ifid_le),
      .ifid_clr(u1_clr),
      .fwd_a(u1_fwd_a), .fwd_b(u1_fwd_b), .fwd_c(u1_fwd_c),
      .stall_cnt(u1_scnt)
   );

   hazard_scheduler #(.LOAD_STALL(3), .NREG_W(4)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
      .id_rf_e(id_rf_e), .id_wr_reg(id_wr_reg), .id_load(id_load),
      .br_taken(br_taken),
      .cu_nop_s(u3_nop), .pc_le(u3_pc_le), .ifid_le(u3_ifid_le),
      .ifid_clr(u3_clr),
      .fwd_a(u3_fwd_a), .fwd_b(u3_fwd_b), .fwd_c(u3_fwd_c),
      .stall_cnt(u3_scnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic [3:0] rn, input logic urn,
                      input logic [3:0] rm, input logic urm,
                      input logic [3:0] rd, input logic urd,
                      input logic rf_e, input logic [3:0] wr,
                      input logic ld, input logic br);
      id_rn = rn; id_use_rn = urn;
      id_rm = rm; id_use_rm = urm;
      id_rd = rd; id_use_rd = urd;
      id_rf_e = rf_e; id_wr_reg = wr; id_load = ld; br_taken = br;
   endtask

   task automatic idle();
      drv(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   // Advance one clock; inputs are then driven 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // ---------------- reset state (br_taken and a reader asserted) ----
      rst_n = 1'b0;
      drv(4'd2, 1'b1, 4'd3, 1'b1, 4'd4, 1'b1, 1'b1, 4'd2, 1'b1, 1'b1);
      #2;
      check("rst_nop",     u1_nop,     1'b0);
      check("rst_pc_le",   u1_pc_le,   1'b1);
      check("rst_ifid_le", u1_ifid_le, 1'b1);
      check("rst_clr",     u1_clr,     1'b0);
      check("rst_fwd_a",   u1_fwd_a,   2'b00);
      check("rst_scnt",    u1_scnt,    16'd0);
      check("rst3_nop",    u3_nop,     1'b0);

      // ---------------- load-use, LOAD_STALL=1 and 3 --------------------
      do_reset();
      drv(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0); // LDR R2,[R1]
      #1;
      check("ld_nop",    u1_nop,   1'b0);
      check("ld_pc_le",  u1_pc_le, 1'b1);
      tick();
      drv(4'd2, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0); // ADD R3,R2,R4
      #1;
      check("lu1_nop",     u1_nop,     1'b1);
      check("lu1_pc_le",   u1_pc_le,   1'b0);
      check("lu1_ifid_le", u1_ifid_le, 1'b0);
      check("lu1_clr",     u1_clr,     1'b0);
      check("lu3_nop_c1",  u3_nop,     1'b1);
      tick();
      #1;
      check("lu1_after_nop",   u1_nop,   1'b0);
      check("lu1_after_pc_le", u1_pc_le, 1'b1);
      check("lu1_fwd_a_mem",   u1_fwd_a, 2'b10);
      check("lu1_fwd_b_rf",    u1_fwd_b, 2'b00);
      check("lu1_scnt",        u1_scnt,  16'd1);
      check("lu3_nop_c2",      u3_nop,   1'b1);
      check("lu3_pc_le_c2",    u3_pc_le, 1'b0);
      check("lu3_scnt_c2",     u3_scnt,  16'd1);
      tick();
      #1;
      check("lu3_nop_c3",      u3_nop,   1'b1);
      check("lu3_scnt_c3",     u3_scnt,  16'd2);
      tick();
      #1;
      check("lu3_run_nop",     u3_nop,   1'b0);
      check("lu3_run_pc_le",   u3_pc_le, 1'b1);
      check("lu3_scnt",        u3_scnt,  16'd3);
      check("lu3_fwd_a",       u3_fwd_a, 2'b00);
      check("lu1_scnt_final",  u1_scnt,  16'd1);

      // ---------------- forwarding priority and stage distance ----------
      do_reset();
      drv(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0); // 3x ALU -> R5
      tick();
      tick();
      tick();
      drv(4'd5, 1'b1, 4'd5, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("fw_ex_a",   u1_fwd_a, 2'b01);
      check("fw_ex_b",   u1_fwd_b, 2'b01);
      check("fw_ex_c",   u1_fwd_c, 2'b01);
      check("fw_ex_nop", u1_nop,   1'b0);
      check("fw3_ex_a",  u3_fwd_a, 2'b01);

      do_reset();
      drv(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0); // ALU -> R5
      tick();
      idle();
      tick();
      drv(4'd5, 1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("fw_mem_a",  u1_fwd_a, 2'b10);
      check("fw_miss_b", u1_fwd_b, 2'b00);
      tick();
      #1;
      check("fw_wb_a",   u1_fwd_a, 2'b11);

      // ---------------- taken branch, hazard ignored during FLUSH -------
      do_reset();
      drv(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
      #1;
      check("br_clr",    u1_clr,   1'b1);
      check("br_nop",    u1_nop,   1'b0);
      check("br_pc_le",  u1_pc_le, 1'b1);
      tick();
      drv(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      #1;
      check("fl_nop",     u1_nop,     1'b1);
      check("fl_pc_le",   u1_pc_le,   1'b1);
      check("fl_ifid_le", u1_ifid_le, 1'b1);
      check("fl_clr",     u1_clr,     1'b0);
      check("fl3_pc_le",  u3_pc_le,   1'b1);
      tick();
      drv(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("fl_run_nop", u1_nop,   1'b0);
      check("fl_run_clr", u1_clr,   1'b0);
      check("fl_fwd_a",   u1_fwd_a, 2'b10);
      check("fl_scnt",    u1_scnt,  16'd0);
      check("fl3_scnt",   u3_scnt,  16'd0);

      // ---------------- hazard beats branch -----------------------------
      do_reset();
      drv(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
      tick();
      drv(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      #1;
      check("pri_nop",   u1_nop,   1'b1);
      check("pri_clr",   u1_clr,   1'b0);
      check("pri_pc_le", u1_pc_le, 1'b0);
      tick();
      idle();
      #1;
      check("pri_next_nop",   u1_nop,   1'b0);
      check("pri_next_pc_le", u1_pc_le, 1'b1);

      // ---------------- R15 never stalls nor forwards -------------------
      do_reset();
      drv(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 1'b0);
      tick();
      drv(4'd15, 1'b1, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("pc_nop",    u1_nop,   1'b0);
      check("pc_fwd_a",  u1_fwd_a, 2'b00);
      check("pc3_nop",   u3_nop,   1'b0);
      tick();
      #1;
      check("pc_mem_a",  u1_fwd_a, 2'b00);
      check("pc_mem_c",  u1_fwd_c, 2'b00);

      // ---------------- asynchronous reset in the middle of a stall -----
      do_reset();
      drv(4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
      tick();
      drv(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      tick();
      #1;
      check("mid_stall_nop", u3_nop,  1'b1);
      check("mid_stall_cnt", u3_scnt, 16'd1);
      br_taken = 1'b1;
      rst_n    = 1'b0;
      #1;
      check("ar_nop",     u3_nop,     1'b0);
      check("ar_pc_le",   u3_pc_le,   1'b1);
      check("ar_ifid_le", u3_ifid_le, 1'b1);
      check("ar_clr",     u3_clr,     1'b0);
      check("ar_fwd_a",   u3_fwd_a,   2'b00);
      check("ar_scnt",    u3_scnt,    16'd0);
      check("ar1_fwd_a",  u1_fwd_a,   2'b00);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drv(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      #1;
      check("post_nop",   u3_nop,   1'b0);
      check("post_fwd_a", u3_fwd_a, 2'b00);
      check("post_scnt",  u3_scnt,  16'd0);
      tick();
      #1;
      check("post_scnt2", u3_scnt,  16'd0);
      check("post_nop2",  u3_nop,   1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
